iterative_shift_unit: RTL and testbench



---
 rtl/iterative_shift_unit.sv | 98 +++++++++
 tb/tb_iterative_shift_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/iterative_shift_unit.sv
// Sequential one-bit-per-clock shifter: logical/arithmetic right, rotate right, logical left.
// Operands are captured on an accepted START; the result is held until the next accepted START.
module iterative_shift_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic [7:0]       SHIFT,
    input  logic [1:0]       SHIFT_MODE,
    output logic [WIDTH-1:0] RESULT,
    output logic             BUSY,
    output logic             DONE
);

    localparam int unsigned LOG_W = $clog2(WIDTH);

    localparam logic [1:0] MODE_SRL = 2'b00;
    localparam logic [1:0] MODE_SRA = 2'b01;
    localparam logic [1:0] MODE_ROR = 2'b10;
    localparam logic [1:0] MODE_SLL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [1:0]       mode;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] eff;

    // Rotates wrap modulo WIDTH; all other modes saturate at WIDTH.
    always_comb begin
        eff = '0;
        if (SHIFT_MODE == MODE_ROR) begin
            eff = CNT_W'(SHIFT[LOG_W-1:0]);
        end else if (32'(SHIFT) >= WIDTH) begin
            eff = CNT_W'(WIDTH);
        end else begin
            eff = CNT_W'(SHIFT);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= ST_IDLE;
            work   <= '0;
            mode   <= MODE_SRL;
            count  <= '0;
            RESULT <= '0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_FIN: begin
                    DONE <= 1'b0;
                    if (START) begin
                        work  <= DATA_IN;
                        mode  <= SHIFT_MODE;
                        count <= eff;
                        BUSY  <= 1'b1;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (count != '0) begin
                        case (mode)
                            MODE_SRL: work <= {1'b0, work[WIDTH-1:1]};
                            MODE_SRA: work <= {work[WIDTH-1], work[WIDTH-1:1]};
                            MODE_ROR: work <= {work[0], work[WIDTH-1:1]};
                            MODE_SLL: work <= {work[WIDTH-2:0], 1'b0};
                            default:  work <= work;
                        endcase
                        count <= count - CNT_W'(1);
                    end else begin
                        RESULT <= work;
                        BUSY   <= 1'b0;
                        DONE   <= 1'b1;
                        state  <= ST_FIN;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Self-checking bench for iterative_shift_unit: directed table, random ops against a model, corner sequences.
module tb_iterative_shift_unit;

    logic       CLK;
    logic       RESET;
    logic       START;
    logic [7:0] DATA_IN;
    logic [7:0] SHIFT;
    logic [1:0] SHIFT_MODE;
    logic [7:0] RESULT;
    logic       BUSY;
    logic       DONE;

    int vec_cnt = 0;
    int err_cnt = 0;

    iterative_shift_unit #(.WIDTH(8)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .DATA_IN(DATA_IN),
        .SHIFT(SHIFT), .SHIFT_MODE(SHIFT_MODE),
        .RESULT(RESULT), .BUSY(BUSY), .DONE(DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] d;
        logic [7:0] s;
        logic [1:0] m;
        logic [7:0] exp_res;
        int         exp_edges;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: effective count and shifted value computed directly from the mode rules.
    function automatic int model_eff(input logic [7:0] s, input logic [1:0] m);
        if (m == 2'b10) return int'(s) % 8;
        return (int'(s) >= 8) ? 8 : int'(s);
    endfunction

    function automatic logic [7:0] model_res(input logic [7:0] d, input logic [7:0] s, input logic [1:0] m);
        int          e;
        logic [15:0] dd;
        e = model_eff(s, m);
        case (m)
            2'b00:   return (e >= 8) ? 8'h00 : (d >> e);
            2'b01:   return 8'($signed(d) >>> e);
            2'b10: begin
                dd = {d, d} >> e;
                return dd[7:0];
            end
            default: return (e >= 8) ? 8'h00 : 8'(d << e);
        endcase
    endfunction

    // Called #1 after a posedge; counts edges from the capture edge (inclusive) until DONE.
    task automatic run_op(input logic [7:0] d, input logic [7:0] s, input logic [1:0] m,
                          output logic [7:0] res, output int edges, output int busy_cycles);
        DATA_IN = d; SHIFT = s; SHIFT_MODE = m; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        DATA_IN = 8'($urandom); SHIFT = 8'($urandom); SHIFT_MODE = 2'($urandom);
        edges = 1;
        busy_cycles = 0;
        while (!DONE && edges < 20) begin
            if (BUSY) busy_cycles++;
            @(posedge CLK); #1;
            edges++;
        end
        res = RESULT;
    endtask

    initial begin
        logic [7:0] res;
        int         edges;
        int         busy_c;
        int         done_seen;
        logic [7:0] d, s;
        logic [1:0] m;

        tbl[0] = '{8'hB4, 8'd3,   2'b00, 8'h16, 5};
        tbl[1] = '{8'hB4, 8'd3,   2'b01, 8'hF6, 5};
        tbl[2] = '{8'hB4, 8'd3,   2'b11, 8'hA0, 5};
        tbl[3] = '{8'hB4, 8'd11,  2'b10, 8'h96, 5};
        tbl[4] = '{8'hB4, 8'd8,   2'b10, 8'hB4, 2};
        tbl[5] = '{8'h81, 8'd200, 2'b01, 8'hFF, 10};
        tbl[6] = '{8'h81, 8'd200, 2'b00, 8'h00, 10};
        tbl[7] = '{8'h81, 8'd200, 2'b11, 8'h00, 10};
        tbl[8] = '{8'h5A, 8'd0,   2'b01, 8'h5A, 2};

        RESET = 1'b1; START = 1'b0; DATA_IN = '0; SHIFT = '0; SHIFT_MODE = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_result", 32'(RESULT), 32'h0);
        check("reset_busy",   32'(BUSY),   32'h0);
        check("reset_done",   32'(DONE),   32'h0);
        RESET = 1'b0;
        @(posedge CLK); #1;

        for (int i = 0; i < 9; i++) begin
            run_op(tbl[i].d, tbl[i].s, tbl[i].m, res, edges, busy_c);
            check($sformatf("tbl%0d_result", i), 32'(res), 32'(tbl[i].exp_res));
            check($sformatf("tbl%0d_latency", i), 32'(edges), 32'(tbl[i].exp_edges));
            check($sformatf("tbl%0d_busy_cycles", i), 32'(busy_c), 32'(tbl[i].exp_edges - 1));
            check($sformatf("tbl%0d_busy_at_done", i), 32'(BUSY), 32'h0);
        end

        for (int i = 0; i < 150; i++) begin
            d = 8'($urandom);
            m = 2'($urandom);
            s = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
            run_op(d, s, m, res, edges, busy_c);
            check($sformatf("rnd%0d_result d=%0h s=%0d m=%0d", i, d, s, m), 32'(res), 32'(model_res(d, s, m)));
            check($sformatf("rnd%0d_latency", i), 32'(edges), 32'(model_eff(s, m) + 2));
            if ($urandom_range(0, 1) == 1) begin
                @(posedge CLK); #1;
                check($sformatf("rnd%0d_done_pulse", i), 32'(DONE), 32'h0);
                check($sformatf("rnd%0d_result_held", i), 32'(RESULT), 32'(model_res(d, s, m)));
            end
        end

        // START pulses while busy must be ignored.
        DATA_IN = 8'hB4; SHIFT = 8'd3; SHIFT_MODE = 2'b00; START = 1'b1;
        @(posedge CLK); #1;
        DATA_IN = 8'hFF; SHIFT = 8'd0; SHIFT_MODE = 2'b11;
        repeat (2) begin @(posedge CLK); #1; end
        START = 1'b0;
        edges = 3;
        while (!DONE && edges < 20) begin @(posedge CLK); #1; edges++; end
        check("busy_ignore_result",  32'(RESULT), 32'h16);
        check("busy_ignore_latency", 32'(edges),  32'd5);

        // Back-to-back: START in the DONE cycle is accepted.
        DATA_IN = 8'h81; SHIFT = 8'd1; SHIFT_MODE = 2'b00; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        check("b2b_busy", 32'(BUSY), 32'h1);
        check("b2b_done", 32'(DONE), 32'h0);
        edges = 1;
        while (!DONE && edges < 20) begin @(posedge CLK); #1; edges++; end
        check("b2b_result",  32'(RESULT), 32'h40);
        check("b2b_latency", 32'(edges),  32'd3);

        // Reset mid-run aborts without a DONE.
        run_op(8'hB4, 8'd6, 2'b00, res, edges, busy_c);
        check("pre_abort_result", 32'(res), 32'h02);
        DATA_IN = 8'hB4; SHIFT = 8'd6; SHIFT_MODE = 2'b00; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (2) begin @(posedge CLK); #1; end
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        check("abort_busy",   32'(BUSY),   32'h0);
        check("abort_done",   32'(DONE),   32'h0);
        check("abort_result", 32'(RESULT), 32'h0);
        done_seen = 0;
        repeat (12) begin
            @(posedge CLK); #1;
            if (DONE || BUSY) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
